// File: rtl/trace_mem_ctrl.sv
// Trace buffer / stream FIFO responder for the tracer store/load word interface.
// Trace mode: circular capture with trigger-delay freeze. Stream mode: FIFO plus host mailbox.
module trace_mem_ctrl #(
  parameter int TRB_WIDTH      = 32,
  parameter int TRB_DEPTH      = 8,
  parameter int TRB_DELAY_BITS = 8
) (
  input  logic                         CLK_I,
  input  logic                         RSTN_I,
  input  logic [1:0]                   MODE_I,
  input  logic [TRB_DELAY_BITS-1:0]    TRG_DELAY_I,
  input  logic                         TRG_EVENT_I,
  input  logic [$clog2(TRB_WIDTH)-1:0] EVENT_POS_I,
  output logic [$clog2(TRB_WIDTH)-1:0] EVENT_POS_O,
  output logic [$clog2(TRB_DEPTH)-1:0] TRG_ADDR_O,
  output logic                         TRG_DELAYED_O,
  input  logic                         STORE_I,
  input  logic [TRB_WIDTH-1:0]         DATA_I,
  output logic                         STORE_PERM_O,
  input  logic                         LOAD_REQUEST_I,
  output logic                         LOAD_GRANT_O,
  output logic [TRB_WIDTH-1:0]         DATA_O,
  input  logic                         HOST_WRITE_I,
  input  logic [TRB_WIDTH-1:0]         HOST_WDATA_I,
  output logic                         HOST_WREADY_O,
  input  logic                         HOST_READ_I,
  output logic [TRB_WIDTH-1:0]         HOST_RDATA_O,
  output logic                         HOST_RVALID_O
);

  localparam int AW = $clog2(TRB_DEPTH);
  localparam int PW = $clog2(TRB_WIDTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(TRB_DEPTH);

  logic [TRB_WIDTH-1:0]      r_mem [TRB_DEPTH];
  logic [AW-1:0]             r_wr_ptr, r_rd_ptr, r_trg_addr;
  logic [AW:0]               r_count, r_rd_left;
  logic                      r_trig_seen, r_frozen, r_mbox_full, r_grant, r_init;
  logic [TRB_DELAY_BITS-1:0] r_delay_cnt;
  logic [1:0]                r_mode_q;
  logic [PW-1:0]             r_event_pos;
  logic [TRB_WIDTH-1:0]      r_mbox, r_data_o;

  logic w_stream, w_mode_chg, w_cnt_full, w_cnt_empty, w_freeze, w_trig_rise;
  logic w_push, w_rvalid, w_pop, w_mbox_wr, w_grant, w_perm;

  always_comb begin
    w_stream    = (MODE_I != 2'b00);
    // r_init masks the first edge after reset so the reset value of r_mode_q never fakes a mode change
    w_mode_chg  = r_init && (MODE_I != r_mode_q);
    w_cnt_full  = (r_count == DEPTH_C);
    w_cnt_empty = (r_count == '0);
    w_freeze    = !w_stream && r_trig_seen && !r_frozen && (r_delay_cnt == TRG_DELAY_I);
    w_trig_rise = !w_stream && TRG_EVENT_I && !r_trig_seen;
    // in trace mode the store landing on the freeze edge is discarded: exactly TRG_DELAY_I follow the trigger
    w_push      = !w_mode_chg && STORE_I &&
                  (w_stream ? !w_cnt_full : (!r_frozen && !w_freeze));
    w_rvalid    = w_stream ? !w_cnt_empty : (r_frozen && (r_rd_left != '0));
    w_pop       = !w_mode_chg && HOST_READ_I && w_rvalid;
    w_mbox_wr   = !w_mode_chg && w_stream && HOST_WRITE_I && !r_mbox_full;
    w_grant     = !w_mode_chg && LOAD_REQUEST_I && !r_grant && (!w_stream || r_mbox_full);
    w_perm      = w_stream ?
                  (({1'b0, r_count} + {{(AW+1){1'b0}}, STORE_I}) < {1'b0, DEPTH_C}) :
                  !r_frozen;
  end

  always_ff @(posedge CLK_I) begin
    if (RSTN_I && w_push) r_mem[r_wr_ptr] <= DATA_I;
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      r_init      <= 1'b0;
      r_mode_q    <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_left   <= '0;
      r_trig_seen <= 1'b0;
      r_delay_cnt <= '0;
      r_frozen    <= 1'b0;
      r_mbox_full <= 1'b0;
      r_mbox      <= '0;
      r_grant     <= 1'b0;
      r_data_o    <= '0;
      r_trg_addr  <= '0;
      r_event_pos <= '0;
    end else begin
      r_init   <= 1'b1;
      r_mode_q <= MODE_I;
      r_grant  <= w_grant;
      if (w_grant) r_data_o <= w_stream ? r_mbox : r_mem[r_wr_ptr];
      if (w_mode_chg) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_rd_left   <= '0;
        r_trig_seen <= 1'b0;
        r_delay_cnt <= '0;
        r_frozen    <= 1'b0;
        r_mbox_full <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_stream) begin
          if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
          if (w_push && !w_pop)      r_count <= r_count + 1'b1;
          else if (!w_push && w_pop) r_count <= r_count - 1'b1;
          if (w_mbox_wr) begin
            r_mbox      <= HOST_WDATA_I;
            r_mbox_full <= 1'b1;
          end else if (w_grant) begin
            r_mbox_full <= 1'b0;
          end
        end else begin
          if (w_trig_rise) begin
            r_trig_seen <= 1'b1;
            r_trg_addr  <= r_wr_ptr;
            r_event_pos <= EVENT_POS_I;
            r_delay_cnt <= '0;
          end else if (r_trig_seen && !r_frozen && w_push) begin
            r_delay_cnt <= r_delay_cnt + 1'b1;
          end
          if (w_freeze) begin
            r_frozen  <= 1'b1;
            r_rd_ptr  <= r_wr_ptr;
            r_rd_left <= DEPTH_C;
          end else if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_rd_left <= r_rd_left - 1'b1;
          end
        end
      end
    end
  end

  assign STORE_PERM_O  = w_perm;
  assign TRG_DELAYED_O = !w_stream && r_frozen;
  assign TRG_ADDR_O    = r_trg_addr;
  assign EVENT_POS_O   = r_event_pos;
  assign LOAD_GRANT_O  = r_grant;
  assign DATA_O        = r_data_o;
  assign HOST_WREADY_O = !r_mbox_full;
  assign HOST_RVALID_O = w_rvalid;
  assign HOST_RDATA_O  = w_rvalid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_trace_mem_ctrl.sv
// Directed bench for trace_mem_ctrl: trace capture/freeze/readout, stream FIFO, mailbox, mode change, reset.
module tb_trace_mem_ctrl;

  logic        CLK_I = 1'b0;
  logic        RSTN_I;
  logic [1:0]  MODE_I;
  logic [7:0]  TRG_DELAY_I;
  logic        TRG_EVENT_I;
  logic [4:0]  EVENT_POS_I;
  logic [4:0]  EVENT_POS_O;
  logic [2:0]  TRG_ADDR_O;
  logic        TRG_DELAYED_O;
  logic        STORE_I;
  logic [31:0] DATA_I;
  logic        STORE_PERM_O;
  logic        LOAD_REQUEST_I;
  logic        LOAD_GRANT_O;
  logic [31:0] DATA_O;
  logic        HOST_WRITE_I;
  logic [31:0] HOST_WDATA_I;
  logic        HOST_WREADY_O;
  logic        HOST_READ_I;
  logic [31:0] HOST_RDATA_O;
  logic        HOST_RVALID_O;

  int n_cmp = 0;
  int n_bad = 0;

  trace_mem_ctrl #(.TRB_WIDTH(32), .TRB_DEPTH(8), .TRB_DELAY_BITS(8)) dut (
    .CLK_I(CLK_I), .RSTN_I(RSTN_I), .MODE_I(MODE_I), .TRG_DELAY_I(TRG_DELAY_I),
    .TRG_EVENT_I(TRG_EVENT_I), .EVENT_POS_I(EVENT_POS_I), .EVENT_POS_O(EVENT_POS_O),
    .TRG_ADDR_O(TRG_ADDR_O), .TRG_DELAYED_O(TRG_DELAYED_O), .STORE_I(STORE_I),
    .DATA_I(DATA_I), .STORE_PERM_O(STORE_PERM_O), .LOAD_REQUEST_I(LOAD_REQUEST_I),
    .LOAD_GRANT_O(LOAD_GRANT_O), .DATA_O(DATA_O), .HOST_WRITE_I(HOST_WRITE_I),
    .HOST_WDATA_I(HOST_WDATA_I), .HOST_WREADY_O(HOST_WREADY_O), .HOST_READ_I(HOST_READ_I),
    .HOST_RDATA_O(HOST_RDATA_O), .HOST_RVALID_O(HOST_RVALID_O)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic step();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic idle_inputs();
    TRG_DELAY_I = 8'd0; TRG_EVENT_I = 1'b0; EVENT_POS_I = 5'd0;
    STORE_I = 1'b0; DATA_I = '0; LOAD_REQUEST_I = 1'b0;
    HOST_WRITE_I = 1'b0; HOST_WDATA_I = '0; HOST_READ_I = 1'b0;
  endtask

  task automatic do_reset(input logic [1:0] mode);
    RSTN_I = 1'b0;
    MODE_I = mode;
    idle_inputs();
    #13;
    @(negedge CLK_I);
    RSTN_I = 1'b1;
    step();
  endtask

  task automatic test_reset();
    RSTN_I = 1'b0; MODE_I = 2'd0; idle_inputs();
    #7;
    n_cmp++; if (STORE_PERM_O !== 1'b1)  begin n_bad++; $display("FAIL rst_perm: got %b want 1", STORE_PERM_O); end
    n_cmp++; if (LOAD_GRANT_O !== 1'b0)  begin n_bad++; $display("FAIL rst_grant: got %b want 0", LOAD_GRANT_O); end
    n_cmp++; if (TRG_DELAYED_O !== 1'b0) begin n_bad++; $display("FAIL rst_delayed: got %b want 0", TRG_DELAYED_O); end
    n_cmp++; if (HOST_RVALID_O !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %b want 0", HOST_RVALID_O); end
    n_cmp++; if (HOST_WREADY_O !== 1'b1) begin n_bad++; $display("FAIL rst_wready: got %b want 1", HOST_WREADY_O); end
    n_cmp++; if (DATA_O !== 32'h0)       begin n_bad++; $display("FAIL rst_data: got %h want 0", DATA_O); end
    n_cmp++; if (HOST_RDATA_O !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", HOST_RDATA_O); end
    n_cmp++; if (TRG_ADDR_O !== 3'd0)    begin n_bad++; $display("FAIL rst_trg_addr: got %0d want 0", TRG_ADDR_O); end
    n_cmp++; if (EVENT_POS_O !== 5'd0)   begin n_bad++; $display("FAIL rst_event_pos: got %0d want 0", EVENT_POS_O); end
    MODE_I = 2'd1;
    #1;
    n_cmp++; if (STORE_PERM_O !== 1'b1)  begin n_bad++; $display("FAIL rst_perm_stream: got %b want 1", STORE_PERM_O); end
  endtask

  task automatic test_trace_capture();
    do_reset(2'd0);
    TRG_DELAY_I = 8'd3;
    for (int i = 0; i < 12; i++) begin
      DATA_I = 32'(i);
      STORE_I = 1'b1;
      TRG_EVENT_I = (i >= 6);
      EVENT_POS_I = (i == 6) ? 5'd17 : 5'd4;
      step();
      n_cmp++;
      if (TRG_DELAYED_O !== (i >= 10))
        begin n_bad++; $display("FAIL trace_delayed_%0d: got %b want %b", i, TRG_DELAYED_O, (i >= 10)); end
    end
    STORE_I = 1'b0;
    #1;
    n_cmp++; if (TRG_ADDR_O !== 3'd6)   begin n_bad++; $display("FAIL trace_trg_addr: got %0d want 6", TRG_ADDR_O); end
    n_cmp++; if (EVENT_POS_O !== 5'd17) begin n_bad++; $display("FAIL trace_event_pos: got %0d want 17", EVENT_POS_O); end
    n_cmp++; if (STORE_PERM_O !== 1'b0) begin n_bad++; $display("FAIL trace_perm: got %b want 0", STORE_PERM_O); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (HOST_RVALID_O !== 1'b1) begin n_bad++; $display("FAIL trace_rvalid_%0d: got %b want 1", k, HOST_RVALID_O); end
      n_cmp++; if (HOST_RDATA_O !== 32'(k + 2))
        begin n_bad++; $display("FAIL trace_rdata_%0d: got %0d want %0d", k, HOST_RDATA_O, k + 2); end
      HOST_READ_I = 1'b1;
      step();
      HOST_READ_I = 1'b0;
    end
    n_cmp++; if (HOST_RVALID_O !== 1'b0) begin n_bad++; $display("FAIL trace_rvalid_end: got %b want 0", HOST_RVALID_O); end
    LOAD_REQUEST_I = 1'b1;
    step();
    n_cmp++; if (LOAD_GRANT_O !== 1'b1) begin n_bad++; $display("FAIL trace_grant: got %b want 1", LOAD_GRANT_O); end
    n_cmp++; if (DATA_O !== 32'd2)      begin n_bad++; $display("FAIL trace_load_data: got %0d want 2", DATA_O); end
    step();
    n_cmp++; if (LOAD_GRANT_O !== 1'b0) begin n_bad++; $display("FAIL trace_grant_b2b: got %b want 0", LOAD_GRANT_O); end
    LOAD_REQUEST_I = 1'b0;
  endtask

  task automatic test_trigger_delay0();
    do_reset(2'd0);
    for (int i = 0; i < 3; i++) begin
      DATA_I = 32'h30 + 32'(i);
      STORE_I = 1'b1;
      step();
    end
    STORE_I = 1'b0;
    TRG_EVENT_I = 1'b1;
    EVENT_POS_I = 5'd9;
    step();
    n_cmp++; if (TRG_DELAYED_O !== 1'b0) begin n_bad++; $display("FAIL d0_delayed_early: got %b want 0", TRG_DELAYED_O); end
    n_cmp++; if (TRG_ADDR_O !== 3'd3)    begin n_bad++; $display("FAIL d0_trg_addr: got %0d want 3", TRG_ADDR_O); end
    EVENT_POS_I = 5'd3;
    step();
    n_cmp++; if (TRG_DELAYED_O !== 1'b1) begin n_bad++; $display("FAIL d0_delayed: got %b want 1", TRG_DELAYED_O); end
    n_cmp++; if (STORE_PERM_O !== 1'b0)  begin n_bad++; $display("FAIL d0_perm: got %b want 0", STORE_PERM_O); end
    n_cmp++; if (EVENT_POS_O !== 5'd9)   begin n_bad++; $display("FAIL d0_event_pos: got %0d want 9", EVENT_POS_O); end
    TRG_EVENT_I = 1'b0;
  endtask

  task automatic test_stream_fifo();
    do_reset(2'd1);
    for (int i = 0; i < 8; i++) begin
      DATA_I = 32'h100 + 32'(i);
      STORE_I = 1'b1;
      #1;
      n_cmp++; if (STORE_PERM_O !== (i < 7))
        begin n_bad++; $display("FAIL fifo_perm_%0d: got %b want %b", i, STORE_PERM_O, (i < 7)); end
      step();
    end
    STORE_I = 1'b0;
    #1;
    n_cmp++; if (STORE_PERM_O !== 1'b0)     begin n_bad++; $display("FAIL fifo_perm_full: got %b want 0", STORE_PERM_O); end
    n_cmp++; if (HOST_RVALID_O !== 1'b1)    begin n_bad++; $display("FAIL fifo_rvalid: got %b want 1", HOST_RVALID_O); end
    n_cmp++; if (HOST_RDATA_O !== 32'h100)  begin n_bad++; $display("FAIL fifo_head: got %h want 100", HOST_RDATA_O); end
    HOST_READ_I = 1'b1;
    step();
    HOST_READ_I = 1'b0;
    #1;
    n_cmp++; if (HOST_RDATA_O !== 32'h101)  begin n_bad++; $display("FAIL fifo_pop1: got %h want 101", HOST_RDATA_O); end
    n_cmp++; if (STORE_PERM_O !== 1'b1)     begin n_bad++; $display("FAIL fifo_perm_7: got %b want 1", STORE_PERM_O); end
    STORE_I = 1'b1; DATA_I = 32'h108; HOST_READ_I = 1'b1;
    #1;
    n_cmp++; if (STORE_PERM_O !== 1'b0)     begin n_bad++; $display("FAIL fifo_perm_inflight: got %b want 0", STORE_PERM_O); end
    step();
    STORE_I = 1'b0; HOST_READ_I = 1'b0;
    for (int k = 0; k < 7; k++) begin
      n_cmp++; if (HOST_RVALID_O !== 1'b1) begin n_bad++; $display("FAIL fifo_rvalid_%0d: got %b want 1", k, HOST_RVALID_O); end
      n_cmp++; if (HOST_RDATA_O !== 32'h102 + 32'(k))
        begin n_bad++; $display("FAIL fifo_drain_%0d: got %h want %h", k, HOST_RDATA_O, 32'h102 + 32'(k)); end
      HOST_READ_I = 1'b1;
      step();
      HOST_READ_I = 1'b0;
    end
    n_cmp++; if (HOST_RVALID_O !== 1'b0) begin n_bad++; $display("FAIL fifo_empty: got %b want 0", HOST_RVALID_O); end
    n_cmp++; if (HOST_RDATA_O !== 32'h0) begin n_bad++; $display("FAIL fifo_empty_data: got %h want 0", HOST_RDATA_O); end
  endtask

  task automatic test_mailbox();
    do_reset(2'd1);
    LOAD_REQUEST_I = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (LOAD_GRANT_O !== 1'b0) begin n_bad++; $display("FAIL mbox_nogrant_%0d: got %b want 0", i, LOAD_GRANT_O); end
    end
    n_cmp++; if (HOST_WREADY_O !== 1'b1) begin n_bad++; $display("FAIL mbox_wready_empty: got %b want 1", HOST_WREADY_O); end
    HOST_WRITE_I = 1'b1; HOST_WDATA_I = 32'hA5A5A5A5;
    step();
    HOST_WRITE_I = 1'b0; HOST_WDATA_I = 32'h0;
    n_cmp++; if (HOST_WREADY_O !== 1'b0) begin n_bad++; $display("FAIL mbox_wready_full: got %b want 0", HOST_WREADY_O); end
    n_cmp++; if (LOAD_GRANT_O !== 1'b0)  begin n_bad++; $display("FAIL mbox_grant_early: got %b want 0", LOAD_GRANT_O); end
    step();
    n_cmp++; if (LOAD_GRANT_O !== 1'b1)      begin n_bad++; $display("FAIL mbox_grant: got %b want 1", LOAD_GRANT_O); end
    n_cmp++; if (DATA_O !== 32'hA5A5A5A5)    begin n_bad++; $display("FAIL mbox_data: got %h want a5a5a5a5", DATA_O); end
    n_cmp++; if (HOST_WREADY_O !== 1'b1)     begin n_bad++; $display("FAIL mbox_wready_back: got %b want 1", HOST_WREADY_O); end
    step();
    n_cmp++; if (LOAD_GRANT_O !== 1'b0)      begin n_bad++; $display("FAIL mbox_grant_once: got %b want 0", LOAD_GRANT_O); end
    n_cmp++; if (DATA_O !== 32'hA5A5A5A5)    begin n_bad++; $display("FAIL mbox_data_hold: got %h want a5a5a5a5", DATA_O); end
    LOAD_REQUEST_I = 1'b0;
  endtask

  task automatic test_mode_switch();
    do_reset(2'd0);
    TRG_DELAY_I = 8'd10;
    for (int i = 0; i < 5; i++) begin
      DATA_I = 32'h50 + 32'(i);
      STORE_I = 1'b1;
      TRG_EVENT_I = (i >= 2);
      step();
    end
    STORE_I = 1'b0;
    n_cmp++; if (TRG_ADDR_O !== 3'd2) begin n_bad++; $display("FAIL mode_trg_addr: got %0d want 2", TRG_ADDR_O); end
    MODE_I = 2'd1;
    step();
    n_cmp++; if (HOST_RVALID_O !== 1'b0) begin n_bad++; $display("FAIL mode_rvalid: got %b want 0", HOST_RVALID_O); end
    n_cmp++; if (TRG_DELAYED_O !== 1'b0) begin n_bad++; $display("FAIL mode_delayed: got %b want 0", TRG_DELAYED_O); end
    n_cmp++; if (STORE_PERM_O !== 1'b1)  begin n_bad++; $display("FAIL mode_perm: got %b want 1", STORE_PERM_O); end
    STORE_I = 1'b1; DATA_I = 32'h77;
    step();
    STORE_I = 1'b0;
    n_cmp++; if (HOST_RDATA_O !== 32'h77) begin n_bad++; $display("FAIL mode_stream_head: got %h want 77", HOST_RDATA_O); end
    MODE_I = 2'd0; TRG_DELAY_I = 8'd0;
    step();
    n_cmp++; if (TRG_ADDR_O !== 3'd2)    begin n_bad++; $display("FAIL mode_trg_addr_kept: got %0d want 2", TRG_ADDR_O); end
    step();
    n_cmp++; if (TRG_ADDR_O !== 3'd0)    begin n_bad++; $display("FAIL mode_retrigger_addr: got %0d want 0", TRG_ADDR_O); end
    n_cmp++; if (TRG_DELAYED_O !== 1'b0) begin n_bad++; $display("FAIL mode_retrigger_early: got %b want 0", TRG_DELAYED_O); end
    step();
    n_cmp++; if (TRG_DELAYED_O !== 1'b1)  begin n_bad++; $display("FAIL mode_retrigger_frozen: got %b want 1", TRG_DELAYED_O); end
    n_cmp++; if (HOST_RDATA_O !== 32'h77) begin n_bad++; $display("FAIL mode_mem_kept: got %h want 77", HOST_RDATA_O); end
    TRG_EVENT_I = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset(2'd1);
    HOST_WRITE_I = 1'b1; HOST_WDATA_I = 32'h1234ABCD;
    step();
    HOST_WRITE_I = 1'b0;
    LOAD_REQUEST_I = 1'b1;
    step();
    n_cmp++; if (LOAD_GRANT_O !== 1'b1) begin n_bad++; $display("FAIL rstg_grant: got %b want 1", LOAD_GRANT_O); end
    #2;
    RSTN_I = 1'b0;
    #1;
    n_cmp++; if (LOAD_GRANT_O !== 1'b0)  begin n_bad++; $display("FAIL rstg_grant_async: got %b want 0", LOAD_GRANT_O); end
    n_cmp++; if (DATA_O !== 32'h0)       begin n_bad++; $display("FAIL rstg_data: got %h want 0", DATA_O); end
    n_cmp++; if (HOST_WREADY_O !== 1'b1) begin n_bad++; $display("FAIL rstg_wready: got %b want 1", HOST_WREADY_O); end
    n_cmp++; if (STORE_PERM_O !== 1'b1)  begin n_bad++; $display("FAIL rstg_perm: got %b want 1", STORE_PERM_O); end
    n_cmp++; if (HOST_RVALID_O !== 1'b0) begin n_bad++; $display("FAIL rstg_rvalid: got %b want 0", HOST_RVALID_O); end
    LOAD_REQUEST_I = 1'b0;
    @(negedge CLK_I);
    RSTN_I = 1'b1;
    step();
    n_cmp++; if (LOAD_GRANT_O !== 1'b0)  begin n_bad++; $display("FAIL rstg_after_grant: got %b want 0", LOAD_GRANT_O); end
    n_cmp++; if (HOST_RVALID_O !== 1'b0) begin n_bad++; $display("FAIL rstg_after_rvalid: got %b want 0", HOST_RVALID_O); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_trace_capture();
    test_trigger_delay0();
    test_stream_fifo();
    test_mailbox();
    test_mode_switch();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
